// File: rtl/one_wire_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : one_wire_rx_frame
// Brief    : 1-Wire slave receiver. Classifies master low pulses by width,
//            answers resets with a presence pulse and queues received bytes.
// Revision : 1.0 - initial release
// ============================================================================
module one_wire_rx_frame #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int GLITCH_CYC   = 4,
    parameter int RESET_MIN_US = 450,
    parameter int ONE_MAX_US   = 15,
    parameter int ZERO_MIN_US  = 45,
    parameter int ZERO_MAX_US  = 120,
    parameter int PRES_WAIT_US = 30,
    parameter int PRES_LEN_US  = 120,
    parameter int MSB_FIRST    = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          ow_in,
    output logic                          ow_drive_low,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          reset_seen,
    output logic                          presence_active,
    output logic                          bit_error,
    output logic                          overflow
);

    localparam int c_TICK_DIV = CLK_HZ / 1_000_000;
    localparam int c_PRE_W    = $clog2(c_TICK_DIV);
    localparam int c_GL_W     = $clog2(GLITCH_CYC + 1);
    localparam int c_PTR_W    = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W    = c_PTR_W + 1;

    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(c_TICK_DIV - 1);
    localparam logic [c_GL_W-1:0]  c_GL_MAX  = c_GL_W'(GLITCH_CYC - 1);

    localparam logic [9:0] c_RESET_MIN      = 10'(RESET_MIN_US);
    localparam logic [9:0] c_ONE_MAX        = 10'(ONE_MAX_US);
    localparam logic [9:0] c_ZERO_MIN       = 10'(ZERO_MIN_US);
    localparam logic [9:0] c_ZERO_MAX       = 10'(ZERO_MAX_US);
    localparam logic [9:0] c_PRES_WAIT_LAST = 10'(PRES_WAIT_US - 1);
    localparam logic [9:0] c_PRES_LEN_LAST  = 10'(PRES_LEN_US - 1);
    localparam logic [9:0] c_WIDTH_SAT      = 10'd1023;

    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] c_ST_IDLE         = 3'd0;
    localparam logic [2:0] c_ST_ARMED        = 3'd1;
    localparam logic [2:0] c_ST_LOW          = 3'd2;
    localparam logic [2:0] c_ST_PRES_WAIT    = 3'd3;
    localparam logic [2:0] c_ST_PRES_DRIVE   = 3'd4;
    localparam logic [2:0] c_ST_PRES_RECOVER = 3'd5;

    logic [1:0]          r_sync;
    logic                r_line;
    logic                r_line_d;
    logic [c_GL_W-1:0]   r_glitch_cnt;
    logic [c_PRE_W-1:0]  r_pre;
    logic [2:0]          r_state;
    logic [9:0]          r_width;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic                r_push;
    logic [7:0]          r_push_data;
    logic                r_reset_seen;
    logic                r_bit_error;
    logic                r_overflow;
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic       w_fall;
    logic       w_rise;
    logic       w_tick;
    logic       w_is_reset;
    logic       w_is_one;
    logic       w_is_zero;
    logic       w_reset_class;
    logic       w_bit_val;
    logic [7:0] w_shift_next;
    logic       w_pop;
    logic       w_full;
    logic       w_wr;

    // Line changes only after GLITCH_CYC consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync       <= 2'b11;
            r_line       <= 1'b1;
            r_line_d     <= 1'b1;
            r_glitch_cnt <= '0;
        end else begin
            r_sync   <= {r_sync[0], ow_in};
            r_line_d <= r_line;
            if (r_sync[1] != r_line) begin
                if (r_glitch_cnt == c_GL_MAX) begin
                    r_line       <= r_sync[1];
                    r_glitch_cnt <= '0;
                end else begin
                    r_glitch_cnt <= r_glitch_cnt + c_GL_W'(1);
                end
            end else begin
                r_glitch_cnt <= '0;
            end
        end
    end

    assign w_fall = r_line_d & ~r_line;
    assign w_rise = ~r_line_d & r_line;
    assign w_tick = (r_pre == c_PRE_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
        end else if (w_fall || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + c_PRE_W'(1);
        end
    end

    assign w_is_reset    = (r_width >= c_RESET_MIN);
    assign w_is_one      = (r_width != 10'd0) && (r_width <= c_ONE_MAX);
    assign w_is_zero     = (r_width >= c_ZERO_MIN) && (r_width <= c_ZERO_MAX);
    assign w_reset_class = enable && (r_state == c_ST_LOW) && w_rise && w_is_reset;
    assign w_bit_val     = w_is_one;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shift_next = {r_shift[6:0], w_bit_val};
        end else begin : g_lsb_first
            assign w_shift_next = {w_bit_val, r_shift[7:1]};
        end
    endgenerate

    // r_width doubles as the microsecond timer for the presence phases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_width      <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_push       <= 1'b0;
            r_push_data  <= '0;
            r_reset_seen <= 1'b0;
            r_bit_error  <= 1'b0;
        end else begin
            r_push       <= 1'b0;
            r_reset_seen <= 1'b0;
            if (!enable) begin
                r_state   <= c_ST_IDLE;
                r_bit_cnt <= '0;
                r_shift   <= '0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (r_line) r_state <= c_ST_ARMED;
                    end
                    c_ST_ARMED: begin
                        if (w_fall) begin
                            r_state <= c_ST_LOW;
                            r_width <= '0;
                        end
                    end
                    c_ST_LOW: begin
                        if (w_rise) begin
                            r_state <= c_ST_ARMED;
                            if (w_is_reset) begin
                                r_reset_seen <= 1'b1;
                                r_bit_cnt    <= '0;
                                r_shift      <= '0;
                                r_bit_error  <= 1'b0;
                                r_width      <= '0;
                                r_state      <= c_ST_PRES_WAIT;
                            end else if (w_is_one || w_is_zero) begin
                                r_shift   <= w_shift_next;
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                                if (r_bit_cnt == 3'd7) begin
                                    r_push      <= 1'b1;
                                    r_push_data <= w_shift_next;
                                end
                            end else begin
                                r_bit_error <= 1'b1;
                                r_bit_cnt   <= '0;
                                r_shift     <= '0;
                            end
                        end else if (w_tick && (r_width != c_WIDTH_SAT)) begin
                            r_width <= r_width + 10'd1;
                        end
                    end
                    c_ST_PRES_WAIT: begin
                        if (w_tick) begin
                            if (r_width == c_PRES_WAIT_LAST) begin
                                r_width <= '0;
                                r_state <= c_ST_PRES_DRIVE;
                            end else begin
                                r_width <= r_width + 10'd1;
                            end
                        end
                    end
                    c_ST_PRES_DRIVE: begin
                        if (w_tick) begin
                            if (r_width == c_PRES_LEN_LAST) begin
                                r_width <= '0;
                                r_state <= c_ST_PRES_RECOVER;
                            end else begin
                                r_width <= r_width + 10'd1;
                            end
                        end
                    end
                    c_ST_PRES_RECOVER: begin
                        if (r_line) r_state <= c_ST_ARMED;
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    assign w_pop  = (r_count != '0) && rx_ready;
    assign w_full = (r_count == c_FULL);
    assign w_wr   = r_push && (!w_full || w_pop);

    // When full, a simultaneous pop frees the slot the push lands in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= r_push_data;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_reset_class) begin
                r_overflow <= 1'b0;
            end else if (r_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign ow_drive_low    = enable && (r_state == c_ST_PRES_DRIVE);
    assign presence_active = ow_drive_low;
    assign rx_data         = r_mem[r_rd_ptr];
    assign rx_valid        = (r_count != '0);
    assign rx_count        = r_count;
    assign reset_seen      = r_reset_seen;
    assign bit_error       = r_bit_error;
    assign overflow        = r_overflow;

endmodule
`default_nettype wire
